// File: rtl/alt_vipvfr130_pkg.sv
// Shared types for the VIP frame-reader packet core.
// FSM state encoding and VIP header packet-type codes.
package alt_vipvfr130_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_USER  = 4'h1;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

endpackage

// File: rtl/alt_vipvfr130_prc_cmd_gen.sv
// Read-command engine: splits a packet's words into bursts of at most
// MAX_CMD_WORDS words at consecutive byte addresses.
module alt_vipvfr130_prc_cmd_gen #(
  parameter int BLW           = 19,
  parameter int CLW           = 7,
  parameter int WORD_BYTES    = 32,
  parameter int MAX_CMD_WORDS = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            run,
  input  logic            stop,
  input  logic [31:0]     base,
  input  logic [BLW-1:0]  words,
  input  logic            cmd_ready,
  output logic            cmd_valid,
  output logic [31:0]     cmd_addr,
  output logic [CLW-1:0]  cmd_length
);

  localparam logic [BLW-1:0] MAXW = BLW'(MAX_CMD_WORDS);

  logic [BLW-1:0] remaining;
  logic [BLW-1:0] issued;
  logic [BLW-1:0] len_w;

  assign len_w      = (remaining > MAXW) ? MAXW : remaining;
  assign cmd_length = CLW'(len_w);
  assign cmd_valid  = run & ~stop & (remaining != '0);
  assign cmd_addr   = base + 32'(issued) * 32'(WORD_BYTES);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      issued    <= '0;
    end else if (load) begin
      remaining <= words;
      issued    <= '0;
    end else if (cmd_valid && cmd_ready) begin
      remaining <= remaining - len_w;
      issued    <= issued + len_w;
    end
  end

endmodule

// File: rtl/alt_vipvfr130_prc_core.sv
// VIP frame-reader packet core: header beat, sample stream, completion.
// ALT_VIPVFR130_PRC_ABORT_EN adds enable-drop abort with a DRAIN state.
module alt_vipvfr130_prc_core
  import alt_vipvfr130_pkg::*;
#(
  parameter int BPS              = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int SAMPLES_PER_WORD = 10,
  parameter int WORD_BYTES       = 32,
  parameter int MAX_CMD_WORDS    = 64,
  parameter int PSW              = 22,
  parameter int BLW              = 19,
  parameter int CLW              = 7
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  output logic                            clear_enable,
  output logic                            stopped,
  output logic                            complete,
  input  logic [31:0]                     packet_addr,
  input  logic [3:0]                      packet_type,
  input  logic [PSW-1:0]                  packet_samples,
  input  logic [BLW-1:0]                  packet_words,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [31:0]                     cmd_addr,
  output logic [CLW-1:0]                  cmd_length,
  input  logic                            rd_valid,
  output logic                            rd_ready,
  input  logic [BPS*SYMBOLS_PER_BEAT-1:0] rd_data,
  output logic                            discard,
  input  logic                            ready_out,
  output logic                            valid_out,
  output logic [BPS*SYMBOLS_PER_BEAT-1:0] data_out,
  output logic                            sop_out,
  output logic                            eop_out
);

  localparam int DW = BPS * SYMBOLS_PER_BEAT;
  localparam int IW = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;

  state_t          state_q, state_n;
  logic [31:0]     addr_q;
  logic [3:0]      type_q;
  logic [PSW-1:0]  samples_q;
  logic [PSW-1:0]  sample_cnt;
  logic [IW-1:0]   inword;

  logic start, run, s_beat, last, word_end, abort_now;
  logic rx_beat, word_close;

  assign start    = (state_q == IDLE) & enable;
  assign run      = (state_q == HEADER) | (state_q == STREAM);
  assign s_beat   = (state_q == STREAM) & rd_valid & ready_out;
  assign word_end = (int'(inword) + 1) >= SAMPLES_PER_WORD;
  assign last     = ((sample_cnt + PSW'(1)) == samples_q) | abort_now;

`ifdef ALT_VIPVFR130_PRC_ABORT_EN
  logic           abort_q, d_beat;
  logic [BLW-1:0] words_cmd, words_rx, words_rx_n;

  assign abort_now  = (state_q == STREAM) & (abort_q | ~enable);
  assign d_beat     = (state_q == DRAIN) & rd_valid;
  assign rx_beat    = s_beat | d_beat;
  // The final streamed beat always closes its word (wrap or discard).
  assign word_close = rx_beat & (word_end | (s_beat & last));
  assign words_rx_n = words_rx + BLW'(word_close);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      abort_q   <= 1'b0;
      words_cmd <= '0;
      words_rx  <= '0;
    end else if (start) begin
      abort_q   <= 1'b0;
      words_cmd <= '0;
      words_rx  <= '0;
    end else begin
      if (abort_now) abort_q <= 1'b1;
      if (cmd_valid && cmd_ready)
        words_cmd <= words_cmd + BLW'(cmd_length);
      words_rx <= words_rx_n;
    end
  end
`else
  assign abort_now  = 1'b0;
  assign rx_beat    = s_beat;
  assign word_close = s_beat & (word_end | last);
`endif

  alt_vipvfr130_prc_cmd_gen #(
    .BLW           (BLW),
    .CLW           (CLW),
    .WORD_BYTES    (WORD_BYTES),
    .MAX_CMD_WORDS (MAX_CMD_WORDS)
  ) u_cmd_gen (
    .clock      (clock),
    .reset      (reset),
    .load       (start),
    .run        (run),
    .stop       (abort_now),
    .base       (addr_q),
    .words      (packet_words),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_addr   (cmd_addr),
    .cmd_length (cmd_length)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      type_q     <= '0;
      samples_q  <= '0;
      sample_cnt <= '0;
      inword     <= '0;
    end else begin
      state_q <= state_n;
      if (start) begin
        addr_q     <= packet_addr;
        type_q     <= packet_type;
        samples_q  <= packet_samples;
        sample_cnt <= '0;
        inword     <= '0;
      end else begin
        if (s_beat) sample_cnt <= sample_cnt + PSW'(1);
        if (rx_beat) inword <= word_close ? '0 : inword + IW'(1);
      end
    end
  end

  always_comb begin
    state_n      = state_q;
    stopped      = 1'b0;
    clear_enable = 1'b0;
    complete     = 1'b0;
    valid_out    = 1'b0;
    sop_out      = 1'b0;
    eop_out      = 1'b0;
    data_out     = '0;
    rd_ready     = 1'b0;
    discard      = 1'b0;
    unique case (state_q)
      IDLE: begin
        stopped = 1'b1;
        if (enable) state_n = HEADER;
      end
      HEADER: begin
        valid_out = 1'b1;
        sop_out   = 1'b1;
        data_out  = DW'(type_q);
        eop_out   = (samples_q == '0);
        if (ready_out)
          state_n = (samples_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        valid_out = rd_valid;
        rd_ready  = ready_out;
        data_out  = rd_data;
        eop_out   = last;
        discard   = ready_out & last & ~word_end;
        if (s_beat && last) begin
          state_n = DONE;
`ifdef ALT_VIPVFR130_PRC_ABORT_EN
          if (abort_now) state_n = DRAIN;
`endif
        end
      end
`ifdef ALT_VIPVFR130_PRC_ABORT_EN
      DRAIN: begin
        rd_ready = 1'b1;
        if (words_rx_n >= words_cmd) state_n = DONE;
      end
`endif
      DONE: begin
        complete     = 1'b1;
        clear_enable = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/alt_vipvfr130_prc_core.md
ALT_VIPVFR130_PRC_CORE -- requirements
Module: alt_vipvfr130_prc_core

Interface
REQ-001 Parameters (name, default, meaning), one per line; all SHALL be honoured:
  BPS, 8, bits per symbol
  SYMBOLS_PER_BEAT, 3, symbols in parallel per output beat
  SAMPLES_PER_WORD, 10, samples per memory word (>=1)
  WORD_BYTES, 32, address increment per memory word
  MAX_CMD_WORDS, 64, maximum words per read command (>=1)
  PSW, 22, packet_samples width; BLW, 19, packet_words width; CLW, 7, cmd_length width (2**CLW > MAX_CMD_WORDS)
REQ-002 Ports (name, direction, width, meaning), one per line:
  clock  in  1  single clock
  reset  in  1  asynchronous, active-low reset
  enable  in  1  GO bit from control slave
  clear_enable  out  1  one-cycle pulse clearing GO
  stopped  out  1  high while idle
  complete  out  1  one-cycle completion pulse
  packet_addr  in  32  byte address of first word
  packet_type  in  4  VIP packet type nibble
  packet_samples  in  PSW  samples in packet
  packet_words  in  BLW  memory words in packet
  cmd_valid/cmd_ready  out/in  1/1  read-command handshake
  cmd_addr  out  32  command byte address
  cmd_length  out  CLW  command length in words
  rd_valid/rd_ready  in/out  1/1  unpacked-sample handshake
  rd_data  in  BPS*SYMBOLS_PER_BEAT  unpacked sample
  discard  out  1  with rd_ready: drop rest of current word
  ready_out/valid_out  in/out  1/1  Avalon-ST source, ready latency 0
  data_out  out  BPS*SYMBOLS_PER_BEAT  beat data
  sop_out/eop_out  out  1/1  packet delimiters

Function
REQ-003 FSM states IDLE, HEADER, STREAM, DRAIN, DONE; transfers occur only on valid&ready cycles.
REQ-004 IDLE: stopped=1; enable=1 latches all packet_* inputs and enters HEADER next cycle.
REQ-005 HEADER: valid_out=1, sop_out=1, data_out[3:0]=latched type, other bits 0; on acceptance -> STREAM, or DONE with eop_out=1 on the same beat if packet_samples==0.
REQ-006 Command engine runs concurrently from HEADER entry: while words remaining>0, cmd_valid=1, cmd_length=min(remaining, MAX_CMD_WORDS), cmd_addr=packet_addr+issued_words*WORD_BYTES (32-bit wrap); each accept advances issued_words by cmd_length.
REQ-007 packet_words==0 with packet_samples>0 issues no command; STREAM waits indefinitely (caller error, not detected).
REQ-008 STREAM: valid_out=rd_valid, rd_ready=ready_out, data_out=rd_data (combinational pass-through, zero latency); sop_out=0.
REQ-009 Sample counter counts accepted beats; eop_out=1 on beat packet_samples; that beat -> DONE.
REQ-010 In-word counter wraps at SAMPLES_PER_WORD; discard=1 on the final packet beat when in-word count+1<SAMPLES_PER_WORD, else 0.
REQ-011 DONE: complete=1 and clear_enable=1 for exactly one cycle, then IDLE; a new packet is not started before IDLE is re-entered.
REQ-012 Counters SHALL be PSW/BLW wide with no overflow for inputs within range.

Reset
REQ-013 reset low asynchronously forces IDLE, all counters 0; outputs: stopped=1, all other outputs 0.
REQ-014 Reset mid-packet discards all latched state; no complete pulse is generated.

Configuration
REQ-015 Macro ALT_VIPVFR130_PRC_ABORT_EN defined: enable low during STREAM stops further commands, the next accepted beat carries eop_out=1 (discard=1), then DRAIN holds rd_ready=1, valid_out=0, dropping samples until all words of issued commands are received (word count from in-word wraps and discards), then DONE.
REQ-016 Macro undefined: DRAIN state absent; enable is ignored outside IDLE.

Structure
REQ-017 Shared package alt_vipvfr130_pkg holds the state enum and the header-type localparams.
REQ-018 Sub-module alt_vipvfr130_prc_cmd_gen implements the command engine (REQ-006); the FSM and counters stay in the top.

Verification
REQ-019 samples=20, words=2, SPW=10, MAX_CMD_WORDS=64, ready_out=1 -> one cmd (addr=packet_addr, length 2); header + 20 beats, eop on beat 20, discard=0, one complete pulse.
REQ-020 words=150, MAX_CMD_WORDS=64, addr=0x1000 -> cmds (0x1000,64),(0x1800,64),(0x2000,22).
REQ-021 samples=15, SPW=10 -> discard=1 on beat 15 only.
REQ-022 samples=0 -> single beat sop=eop=1, data[3:0]=type, no cmd, complete next cycle.
REQ-023 ready_out toggled randomly -> data_out order and count identical to REQ-019; no beat lost or duplicated.
REQ-024 With ABORT_EN: enable low after beat 5 of a 30-sample, 3-word packet -> eop on next beat, remaining samples dropped, complete once, stopped=1 afterwards.
